udp_pingpong_buf_ctrl: RTL and testbench
========================================

Name: udp_pingpong_buf_ctrl

Overview:
Controller for the 1024x64 true-dual-port block RAM (Gowin_DPB) in the CAM2PC UDP path. It treats the RAM as two 512-word banks in ping-pong. The camera/packer side streams 64-bit words into the write bank through port A. The UDP transmitter drains the other bank as one packet through port B. Single clock domain; the RAM's clka and clkb are both driven from clk.

Parameters:
DATA_W, 64, word width; must match the RAM.
ADDR_W, 10, RAM address width; the MSB selects the bank.
BANK_WORDS, 512, words per bank, 2**(ADDR_W-1); this is the maximum packet length.

Ports:
clk  in  1  system clock; also drives RAM clka and clkb.
reset  in  1  asynchronous, active-high reset.
wr_valid  in  1  write word offered.
wr_ready  out  1  write word accepted when high together with wr_valid.
wr_data  in  DATA_W  write word.
wr_last  in  1  last word of the packet; qualified by wr_valid & wr_ready.
rd_pkt_avail  out  1  a full bank is ready and the read FSM is IDLE.
rd_pkt_len  out  ADDR_W  word count of the ready bank, 1..512.
rd_start  in  1  pulse that begins a bank read; ignored unless rd_pkt_avail is high.
rd_en  in  1  request the next word; honoured only in READ.
rd_valid  out  1  rd_data is valid.
rd_data  out  DATA_W  read word; passthrough of ram_doutb.
rd_last  out  1  marks the final word; asserted with rd_valid.
rd_abort  in  1  discard the bank being read.
bank_full  out  2  status flag for each bank.
ram_cea, ram_ocea, ram_ceb, ram_oceb  out  1 each  tied to 1.
ram_reseta, ram_resetb  out  1 each  tied to 0.
ram_wrea  out  1  port A write enable.
ram_ada  out  ADDR_W  port A address.
ram_dina  out  DATA_W  port A write data.
ram_wreb  out  1  tied to 0 (port B is read-only).
ram_adb  out  ADDR_W  port B address.
ram_dinb  out  DATA_W  tied to 0.
ram_doutb  in  DATA_W  port B read data.

Behaviour:
- Reset values (asynchronous): wb=0, rb=0, wcnt=0, rcnt=0, full=2'b00, len[*]=0, FSM=IDLE, rd_valid=0, rd_last=0. After reset wr_ready=1, rd_pkt_avail=0.
- Write side:
  - wr_ready = !full[wb].
  - Accept = wr_valid & wr_ready.
  - Port A is driven combinationally: ram_wrea=accept, ram_ada={wb,wcnt[8:0]}, ram_dina=wr_data.
  - On accept, wcnt increments.
  - If wr_last, or wcnt==511: full[wb]<=1, len[wb]<=wcnt+1, wb toggles, wcnt<=0.
- Read FSM, states IDLE, READ, DRAIN:
  - rd_pkt_avail = (state==IDLE) & full[rb]; rd_pkt_len = len[rb].
  - IDLE: rd_start & rd_pkt_avail → READ, rcnt<=0.
  - READ: ram_adb={rb,rcnt[8:0]}; each cycle with rd_en high, rcnt increments. When rd_en & rcnt==len[rb]-1 → DRAIN.
  - DRAIN, one cycle: full[rb]<=0, rb toggles → IDLE.
- Read latency: exactly 1 cycle, since the RAM is in bypass mode with OCE=1.
  - rd_valid is rd_en registered during READ.
  - rd_last is the registered "last address issued" flag.
  - rd_data = ram_doutb.
  - Gaps in rd_en are allowed; while rd_en is low the address holds.
- rd_abort in READ or DRAIN: go to IDLE, free full[rb], toggle rb. rd_valid and rd_last are forced low from the next cycle. rd_abort in IDLE is ignored.
- Simultaneous events:
  - A write completing bank X while a read frees bank Y in the same cycle is legal; both flag updates apply.
  - The writer never targets a full bank and the reader never reads a non-full bank, so X==Y cannot occur.
- Both banks full: wr_ready=0 (backpressure, no data loss). wr_ready rises in the cycle after DRAIN or abort.
- rd_start while not IDLE is ignored. rd_en outside READ is ignored.
- Reset mid-operation discards all bank contents and flags.

Decomposition:
- Package udp_buf_pkg holds:
  - constants DATA_W=64, ADDR_W=10, BANK_WORDS=512;
  - enum rd_state_t {IDLE, READ, DRAIN}.
- One natural sub-module, udp_buf_rd_seq: the read FSM, rcnt, and rd_valid/rd_last generation.
- Bank flags and the write side stay in the top module.

Test Plan:
- 512 back-to-back writes, no wr_last → bank_full=01, rd_pkt_len=512, wr_ready stays 1, word 513 lands at ada=512.
- Write 3 words A,B,C with wr_last on C; rd_start; rd_en held high 3 cycles → rd_valid on 3 cycles, each one cycle after its rd_en, data A,B,C; rd_last only on C; bank_full[0] clears on the cycle after the last rd_en.
- Fill both banks (lengths 5 and 512) → wr_ready=0 while wr_valid is held. Drain bank 0 → wr_ready=1 the cycle after DRAIN. The next accepted write goes to ada=0.
- Gapped rd_en (1,0,0,1,1) on a 3-word bank → rd_valid pattern 1,0,0,1,1 delayed one cycle; data order preserved.
- rd_abort after 2 of 10 words → rd_valid low the next cycle, bank freed, rd_pkt_avail shows the other full bank the following cycle.
- Assert reset mid-read and mid-write → all outputs return to reset values immediately; after release wr_ready=1 and rd_pkt_avail=0.

Source files
------------

// File: rtl/udp_buf_pkg.sv
// Shared constants and the read FSM state type for the ping-pong UDP buffer controller.
package udp_buf_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned BANK_WORDS = 2 ** (ADDR_W - 1);
  localparam int unsigned CNT_W      = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/udp_pingpong_buf_ctrl_if.sv
// Write stream, packet read stream and bank status between the buffer controller and its users.
interface udp_pingpong_buf_ctrl_if;
  import udp_buf_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              rd_pkt_avail;
  logic [ADDR_W-1:0] rd_pkt_len;
  logic              rd_start;
  logic              rd_en;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_abort;
  logic [1:0]        bank_full;

  // master: the buffer controller; slave: the packer and UDP transmitter
  modport master (
    input  wr_valid, wr_data, wr_last, rd_start, rd_en, rd_abort,
    output wr_ready, rd_pkt_avail, rd_pkt_len, rd_valid, rd_data, rd_last, bank_full
  );

  modport slave (
    output wr_valid, wr_data, wr_last, rd_start, rd_en, rd_abort,
    input  wr_ready, rd_pkt_avail, rd_pkt_len, rd_valid, rd_data, rd_last, bank_full
  );

endinterface

// File: rtl/udp_buf_rd_seq.sv
// Read sequencer: walks one full bank through port B and frees it on completion or abort.
module udp_buf_rd_seq
  import udp_buf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              full_rb,
  input  logic [ADDR_W-1:0] len,
  input  logic              rd_start,
  input  logic              rd_en,
  input  logic              rd_abort,
  output logic              pkt_avail,
  output logic [CNT_W-1:0]  rcnt,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              free
);

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             is_last;

  assign is_last = ({1'b0, rcnt_q} == (len - ADDR_W'(1)));

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    free      = 1'b0;
    pkt_avail = 1'b0;
    case (state_q)
      IDLE: begin
        pkt_avail = full_rb;
        if (rd_start && full_rb) begin
          state_d = READ;
          rcnt_d  = '0;
        end
      end
      READ: begin
        // Abort wins over a same-cycle rd_en so no word leaks out after it.
        if (rd_abort) begin
          free    = 1'b1;
          state_d = IDLE;
        end else if (rd_en) begin
          valid_d = 1'b1;
          rcnt_d  = rcnt_q + CNT_W'(1);
          if (is_last) begin
            last_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        free    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rcnt     = rcnt_q;
  assign rd_valid = valid_q;
  assign rd_last  = last_q;

endmodule

// File: rtl/udp_pingpong_buf_ctrl.sv
// Ping-pong controller over a 1024x64 dual-port RAM: port A fills one bank, port B drains the other.
module udp_pingpong_buf_ctrl
  import udp_buf_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  udp_pingpong_buf_ctrl_if.master bus,
  output logic                    ram_cea,
  output logic                    ram_ocea,
  output logic                    ram_ceb,
  output logic                    ram_oceb,
  output logic                    ram_reseta,
  output logic                    ram_resetb,
  output logic                    ram_wrea,
  output logic [ADDR_W-1:0]       ram_ada,
  output logic [DATA_W-1:0]       ram_dina,
  output logic                    ram_wreb,
  output logic [ADDR_W-1:0]       ram_adb,
  output logic [DATA_W-1:0]       ram_dinb,
  input  logic [DATA_W-1:0]       ram_doutb
);

  logic              wb, rb;
  logic [CNT_W-1:0]  wcnt;
  logic [1:0]        full;
  logic [ADDR_W-1:0] len [2];
  logic              accept, wr_done, rd_free;
  logic [CNT_W-1:0]  rcnt;

  assign bus.wr_ready = !full[wb];
  assign accept       = bus.wr_valid & bus.wr_ready;
  assign wr_done      = accept & (bus.wr_last | (wcnt == CNT_W'(BANK_WORDS - 1)));

  // Writer and reader always own different banks, so both flag updates may land together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb     <= 1'b0;
      rb     <= 1'b0;
      wcnt   <= '0;
      full   <= '0;
      len[0] <= '0;
      len[1] <= '0;
    end else begin
      if (accept) begin
        wcnt <= wr_done ? '0 : wcnt + CNT_W'(1);
      end
      if (wr_done) begin
        full[wb] <= 1'b1;
        len[wb]  <= {1'b0, wcnt} + ADDR_W'(1);
        wb       <= ~wb;
      end
      if (rd_free) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

  udp_buf_rd_seq u_rd_seq (
    .clk      (clk),
    .reset    (reset),
    .full_rb  (full[rb]),
    .len      (len[rb]),
    .rd_start (bus.rd_start),
    .rd_en    (bus.rd_en),
    .rd_abort (bus.rd_abort),
    .pkt_avail(bus.rd_pkt_avail),
    .rcnt     (rcnt),
    .rd_valid (bus.rd_valid),
    .rd_last  (bus.rd_last),
    .free     (rd_free)
  );

  assign bus.rd_pkt_len = len[rb];
  assign bus.rd_data    = ram_doutb;
  assign bus.bank_full  = full;

  assign ram_cea    = 1'b1;
  assign ram_ocea   = 1'b1;
  assign ram_ceb    = 1'b1;
  assign ram_oceb   = 1'b1;
  assign ram_reseta = 1'b0;
  assign ram_resetb = 1'b0;
  assign ram_wrea   = accept;
  assign ram_ada    = {wb, wcnt};
  assign ram_dina   = bus.wr_data;
  assign ram_wreb   = 1'b0;
  assign ram_adb    = {rb, rcnt};
  assign ram_dinb   = '0;

endmodule

// File: tb/tb_udp_pingpong_buf_ctrl.sv
// Bench for udp_pingpong_buf_ctrl: vector table, directed corner sequences, random traffic vs model.
module tb_udp_pingpong_buf_ctrl;
  import udp_buf_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  udp_pingpong_buf_ctrl_if bus_if ();

  logic              ram_cea, ram_ocea, ram_ceb, ram_oceb, ram_reseta, ram_resetb;
  logic              ram_wrea, ram_wreb;
  logic [ADDR_W-1:0] ram_ada, ram_adb;
  logic [DATA_W-1:0] ram_dina, ram_dinb, ram_doutb;

  udp_pingpong_buf_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .ram_cea   (ram_cea),
    .ram_ocea  (ram_ocea),
    .ram_ceb   (ram_ceb),
    .ram_oceb  (ram_oceb),
    .ram_reseta(ram_reseta),
    .ram_resetb(ram_resetb),
    .ram_wrea  (ram_wrea),
    .ram_ada   (ram_ada),
    .ram_dina  (ram_dina),
    .ram_wreb  (ram_wreb),
    .ram_adb   (ram_adb),
    .ram_dinb  (ram_dinb),
    .ram_doutb (ram_doutb)
  );

  // Dual-port RAM in bypass mode: one cycle of read latency.
  logic [DATA_W-1:0] ram [1024];
  always @(posedge clk) begin
    if (ram_wrea) ram[ram_ada] <= ram_dina;
    ram_doutb <= ram[ram_adb];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: two banks with a word store, fill/drain bookkeeping and a read cursor.
  bit          m_full [2];
  int          m_len  [2];
  logic [63:0] m_mem  [2][512];
  int          m_wb, m_rb, m_wcnt, m_rcnt;
  int          m_phase;  // 0 waiting for start, 1 reading words, 2 one-cycle release
  bit          m_vld, m_lst;
  logic [63:0] m_rdat;

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0; m_len[0] = 0; m_len[1] = 0;
    m_wb = 0; m_rb = 0; m_wcnt = 0; m_rcnt = 0; m_phase = 0;
    m_vld = 0; m_lst = 0; m_rdat = '0;
  endtask

  task automatic model_check();
    bit rdy;
    rdy = !m_full[m_wb];
    chk("wr_ready", 64'(bus_if.wr_ready), 64'(rdy));
    chk("rd_pkt_avail", 64'(bus_if.rd_pkt_avail), 64'(m_phase == 0 && m_full[m_rb]));
    chk("rd_pkt_len", 64'(bus_if.rd_pkt_len), 64'(m_len[m_rb]));
    chk("bank_full", 64'(bus_if.bank_full), 64'({m_full[1], m_full[0]}));
    chk("ram_wrea", 64'(ram_wrea), 64'(bus_if.wr_valid && rdy));
    if (bus_if.wr_valid && rdy) chk("ram_ada", 64'(ram_ada), 64'(m_wb * 512 + m_wcnt));
    if (m_phase == 1) chk("ram_adb", 64'(ram_adb), 64'(m_rb * 512 + m_rcnt));
    chk("rd_valid", 64'(bus_if.rd_valid), 64'(m_vld));
    chk("rd_last", 64'(bus_if.rd_last), 64'(m_lst));
    if (m_vld) chk("rd_data", bus_if.rd_data, m_rdat);
  endtask

  task automatic model_advance();
    bit acc, done, free, n_vld, n_lst;
    acc   = bus_if.wr_valid && !m_full[m_wb];
    done  = acc && (bus_if.wr_last || m_wcnt == 511);
    free  = 0;
    n_vld = 0;
    n_lst = 0;
    if (acc) m_mem[m_wb][m_wcnt] = bus_if.wr_data;
    if (m_phase == 0) begin
      if (bus_if.rd_start && m_full[m_rb]) begin
        m_phase = 1;
        m_rcnt  = 0;
      end
    end else if (m_phase == 1) begin
      if (bus_if.rd_abort) begin
        free    = 1;
        m_phase = 0;
      end else if (bus_if.rd_en) begin
        n_vld  = 1;
        m_rdat = m_mem[m_rb][m_rcnt];
        if (m_rcnt == m_len[m_rb] - 1) begin
          n_lst   = 1;
          m_phase = 2;
        end else begin
          m_rcnt++;
        end
      end
    end else begin
      free    = 1;
      m_phase = 0;
    end
    m_vld = n_vld;
    m_lst = n_lst;
    if (done) begin
      m_full[m_wb] = 1;
      m_len[m_wb]  = m_wcnt + 1;
      m_wb         = 1 - m_wb;
      m_wcnt       = 0;
    end else if (acc) begin
      m_wcnt++;
    end
    if (free) begin
      m_full[m_rb] = 0;
      m_rb         = 1 - m_rb;
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_in(input bit wv, input logic [63:0] wd, input bit wl, input bit rs,
                        input bit re, input bit ra);
    bus_if.wr_valid = wv;
    bus_if.wr_data  = wd;
    bus_if.wr_last  = wl;
    bus_if.rd_start = rs;
    bus_if.rd_en    = re;
    bus_if.rd_abort = ra;
  endtask

  // Called 1 time unit after inputs change at a negedge; returns at the next negedge.
  task automatic step();
    model_check();
    model_advance();
    @(negedge clk);
  endtask

  task automatic cyc(input bit wv, input logic [63:0] wd, input bit wl, input bit rs,
                     input bit re, input bit ra);
    set_in(wv, wd, wl, rs, re, ra);
    #1;
    step();
  endtask

  task automatic write_pkt(input int n, input bit with_last);
    for (int i = 0; i < n; i++) cyc(1'b1, rnd64(), with_last && (i == n - 1), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic read_pkt(input int n);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n + 2; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_wr_ready", 64'(bus_if.wr_ready), 64'd1);
    chk("rst_avail", 64'(bus_if.rd_pkt_avail), 64'd0);
    chk("rst_valid", 64'(bus_if.rd_valid), 64'd0);
    chk("rst_last", 64'(bus_if.rd_last), 64'd0);
    chk("rst_bank_full", 64'(bus_if.bank_full), 64'd0);
    chk("rst_len", 64'(bus_if.rd_pkt_len), 64'd0);
    chk("rst_ada", 64'(ram_ada), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic        wv;
    logic [63:0] wd;
    logic        wl, rs, re, ra;
    logic        e_ready, e_avail, e_vld, e_lst;
    logic [1:0]  e_full;
    logic [9:0]  e_len;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    bit          got;
    bit          pat [5];
    logic [63:0] da, db, dc;

    da = 64'hA5A5_0000_0000_000A;
    db = 64'h5A5A_0000_0000_000B;
    dc = 64'hC3C3_0000_0000_000C;
    //            wv  wd  wl rs re ra  rdy av  vld lst full len  data
    tbl[0] = '{1'b1, da, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 64'h0};
    tbl[1] = '{1'b1, db, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 64'h0};
    tbl[2] = '{1'b1, dc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 64'h0};
    tbl[3] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 10'd3, 64'h0};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 10'd3, 64'h0};
    tbl[5] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 10'd3, da};
    tbl[6] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 10'd3, db};
    tbl[7] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 10'd3, dc};
    tbl[8] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 10'd0, 64'h0};

    do_reset();
    chk("ram_ties", 64'({ram_cea, ram_ocea, ram_ceb, ram_oceb, ram_reseta, ram_resetb, ram_wreb}),
        64'(7'b1111000));
    chk("ram_dinb", ram_dinb, 64'h0);

    // Three-word packet through the vector table.
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].wv, tbl[i].wd, tbl[i].wl, tbl[i].rs, tbl[i].re, tbl[i].ra);
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(bus_if.wr_ready), 64'(tbl[i].e_ready));
      chk($sformatf("vec%0d_avail", i), 64'(bus_if.rd_pkt_avail), 64'(tbl[i].e_avail));
      chk($sformatf("vec%0d_valid", i), 64'(bus_if.rd_valid), 64'(tbl[i].e_vld));
      chk($sformatf("vec%0d_last", i), 64'(bus_if.rd_last), 64'(tbl[i].e_lst));
      chk($sformatf("vec%0d_full", i), 64'(bus_if.bank_full), 64'(tbl[i].e_full));
      chk($sformatf("vec%0d_len", i), 64'(bus_if.rd_pkt_len), 64'(tbl[i].e_len));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_data", i), bus_if.rd_data, tbl[i].e_data);
      step();
    end

    // 512 writes with no wr_last close bank 0 by count; word 513 opens bank 1.
    do_reset();
    write_pkt(512, 1'b0);
    set_in(1'b1, rnd64(), 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fill512_full", 64'(bus_if.bank_full), 64'(2'b01));
    chk("fill512_len", 64'(bus_if.rd_pkt_len), 64'd512);
    chk("fill512_ready", 64'(bus_if.wr_ready), 64'd1);
    chk("word513_ada", 64'(ram_ada), 64'd512);
    step();
    write_pkt(4, 1'b1);

    // Both banks full: backpressure, then release after bank 0 drains.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rnd64(), 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("bp_ready", 64'(bus_if.wr_ready), 64'd0);
      chk("bp_wrea", 64'(ram_wrea), 64'd0);
      step();
    end
    cyc(1'b1, rnd64(), 1'b0, 1'b1, 1'b0, 1'b0);
    got = 0;
    for (int k = 0; k < 600; k++) begin
      set_in(1'b1, rnd64(), 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      if (bus_if.wr_ready) begin
        got = 1;
        break;
      end
      step();
    end
    chk("drain_ready_rise", 64'(got), 64'd1);
    chk("drain_next_ada", 64'(ram_ada), 64'd0);
    chk("drain_next_wrea", 64'(ram_wrea), 64'd1);
    step();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    read_pkt(5);

    // Gapped rd_en on a 3-word bank.
    do_reset();
    write_pkt(3, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, (i < 5) ? pat[i] : 1'b0, 1'b0);
      #1;
      if (i > 0) chk($sformatf("gap_valid%0d", i), 64'(bus_if.rd_valid), 64'(pat[i-1]));
      step();
    end

    // Abort after two of ten words; the other full bank shows up immediately.
    do_reset();
    write_pkt(10, 1'b1);
    write_pkt(4, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("abort_valid", 64'(bus_if.rd_valid), 64'd0);
    chk("abort_full", 64'(bus_if.bank_full), 64'(2'b10));
    chk("abort_avail", 64'(bus_if.rd_pkt_avail), 64'd1);
    chk("abort_len", 64'(bus_if.rd_pkt_len), 64'd4);
    step();
    read_pkt(4);

    // Reset in the middle of a read with a write in progress.
    write_pkt(6, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, rnd64(), 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, rnd64(), 1'b0, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, rnd64(), 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model, with one reset partway through.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(($urandom % 4) != 0, rnd64(), ($urandom % 32) == 0, ($urandom % 3) == 0,
          ($urandom % 10) < 7, ($urandom % 150) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
